// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for a completed word.
// Latency: data loaded on an edge is valid the following cycle.
// Backpressure: holds data stable while valid && !ready; caller loads only when free_o.
module sipo_out_buf #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    output logic          free_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q && !ready_i;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sipo_stream.sv
// Serial-in/parallel-out deserialiser with partial-word flush and one-word output buffer.
// Latency: word valid the cycle after its completing bit (or the flush) is accepted.
// Backpressure: shifter keeps filling while a word waits; serial_ready_o drops only when shifter and buffer are both occupied.
module sipo_stream #(
    parameter  int OUTPUT_BW = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int LEN_W     = $clog2(OUTPUT_BW + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 serial_data_i,
    input  logic                 serial_valid_i,
    output logic                 serial_ready_o,
    input  logic                 flush_i,
    output logic [OUTPUT_BW-1:0] dout_bus_o,
    output logic [LEN_W-1:0]     dout_len_o,
    output logic                 dout_valid_o,
    input  logic                 dout_ready_i
);

    localparam logic [LEN_W-1:0] FULL = LEN_W'(OUTPUT_BW);

    logic [OUTPUT_BW-1:0] shift_q, shift_d, shift_nxt;
    logic [LEN_W-1:0]     cnt_q, cnt_d, cnt_nxt;
    logic                 fl_pend_q, fl_pend_d;
    logic                 accept, word_full, flush_hit, pend, load, buf_free;

    always_comb begin
        accept    = serial_valid_i && serial_ready_o;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        if (accept) begin
            if (MSB_FIRST) begin
                shift_nxt = {shift_q[OUTPUT_BW-2:0], serial_data_i};
            end else begin
                for (int i = 0; i < OUTPUT_BW; i++) begin
                    if (cnt_q == LEN_W'(i)) shift_nxt[i] = serial_data_i;
                end
            end
            cnt_nxt = cnt_q + LEN_W'(1);
        end

        // A bit completing the word in the flush cycle makes the flush a no-op.
        word_full = (cnt_nxt == FULL);
        flush_hit = flush_i && (cnt_nxt != '0) && !word_full;
        pend      = fl_pend_q || flush_hit;
        load      = buf_free && (word_full || pend);

        shift_d   = shift_nxt;
        cnt_d     = cnt_nxt;
        fl_pend_d = pend;
        if (load) begin
            shift_d   = '0;
            cnt_d     = '0;
            fl_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            fl_pend_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            fl_pend_q <= fl_pend_d;
        end
    end

    assign serial_ready_o = (cnt_q != FULL) && !fl_pend_q;

    sipo_out_buf #(
        .DW(OUTPUT_BW + LEN_W)
    ) u_out_buf (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .load_i  (load),
        .data_i  ({shift_nxt, cnt_nxt}),
        .free_o  (buf_free),
        .valid_o (dout_valid_o),
        .ready_i (dout_ready_i),
        .data_o  ({dout_bus_o, dout_len_o})
    );

endmodule

// File: tb/tb_sipo_stream.sv
// Bench for sipo_stream: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_stream;

    localparam int BW = 8;
    localparam int LW = 4;

    typedef struct packed {
        logic [BW-1:0] bus;
        logic [LW-1:0] len;
    } exp_t;

    logic          clk, reset_ni, serial_data, serial_valid, flush, dout_ready;
    logic [BW-1:0] bus_m, bus_l;
    logic [LW-1:0] len_m, len_l;
    logic          vld_m, vld_l, srdy_m, srdy_l;

    exp_t q_m[$];
    exp_t q_l[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pops_m   = 0;
    int   pops_l   = 0;

    int            m_cnt = 0;
    logic [BW-1:0] m_wm  = '0;
    logic [BW-1:0] m_wl  = '0;

    sipo_stream #(.OUTPUT_BW(BW), .MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk), .reset_ni(reset_ni), .serial_data_i(serial_data),
        .serial_valid_i(serial_valid), .serial_ready_o(srdy_m), .flush_i(flush),
        .dout_bus_o(bus_m), .dout_len_o(len_m), .dout_valid_o(vld_m), .dout_ready_i(dout_ready)
    );

    sipo_stream #(.OUTPUT_BW(BW), .MSB_FIRST(1'b0)) dut_l (
        .clk_i(clk), .reset_ni(reset_ni), .serial_data_i(serial_data),
        .serial_valid_i(serial_valid), .serial_ready_o(srdy_l), .flush_i(flush),
        .dout_bus_o(bus_l), .dout_len_o(len_l), .dout_valid_o(vld_l), .dout_ready_i(dout_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish, required finish");
        $fatal(1);
    end

    // Scoreboard: compare every handshaken word against the expected queues.
    always @(negedge clk) begin
        exp_t e;
        if (reset_ni && vld_m && dout_ready) begin
            n_checks++;
            pops_m++;
            if (q_m.size() == 0) begin
                n_fail++;
                $display("FAIL sb_m unexpected word bus=%h len=%0d, required none", bus_m, len_m);
            end else begin
                e = q_m.pop_front();
                if (bus_m !== e.bus || len_m !== e.len) begin
                    n_fail++;
                    $display("FAIL sb_m bus=%h len=%0d, required bus=%h len=%0d", bus_m, len_m, e.bus, e.len);
                end
            end
        end
        if (reset_ni && vld_l && dout_ready) begin
            n_checks++;
            pops_l++;
            if (q_l.size() == 0) begin
                n_fail++;
                $display("FAIL sb_l unexpected word bus=%h len=%0d, required none", bus_l, len_l);
            end else begin
                e = q_l.pop_front();
                if (bus_l !== e.bus || len_l !== e.len) begin
                    n_fail++;
                    $display("FAIL sb_l bus=%h len=%0d, required bus=%h len=%0d", bus_l, len_l, e.bus, e.len);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_wm  = '0;
        m_wl  = '0;
    endtask

    task automatic model_emit();
        exp_t e;
        e.bus = m_wm;
        e.len = LW'(m_cnt);
        q_m.push_back(e);
        e.bus = m_wl;
        q_l.push_back(e);
        model_clear();
    endtask

    task automatic send_bit(input logic b, input logic fl);
        int t = 0;
        while (!(srdy_m && srdy_l) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout serial_ready m=%b l=%b, required 1 within 200 cycles", srdy_m, srdy_l);
        end
        serial_valid = 1'b1;
        serial_data  = b;
        flush        = fl;
        step();
        serial_valid = 1'b0;
        flush        = 1'b0;
        m_wm         = {m_wm[BW-2:0], b};
        m_wl[m_cnt]  = b;
        m_cnt++;
        if (m_cnt == BW || fl) model_emit();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    task automatic flush_only();
        flush = 1'b1;
        step();
        flush = 1'b0;
        if (m_cnt > 0) model_emit();
    endtask

    task automatic test_reset();
        reset_ni = 1'b1;
        serial_data = 1'b0; serial_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
        #1 reset_ni = 1'b0;
        #1;
        n_checks++;
        if ({vld_m, vld_l, bus_m, bus_l, len_m, len_l} !== '0 || {srdy_m, srdy_l} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset vld=%b%b bus=%h/%h len=%0d/%0d srdy=%b%b, required all 0 and srdy 11",
                     vld_m, vld_l, bus_m, bus_l, len_m, len_l, srdy_m, srdy_l);
        end
        step();
        reset_ni = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] bits = 8'b1011_0010;
        dout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            n_checks++;
            if (srdy_m !== 1'b1 || srdy_l !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_srdy bit%0d srdy=%b%b, required 11", 7 - i, srdy_m, srdy_l);
            end
            send_bit(bits[i], 1'b0);
        end
        n_checks++;
        if (vld_m !== 1'b1 || bus_m !== 8'hB2 || len_m !== 4'd8) begin
            n_fail++;
            $display("FAIL basic_msb vld=%b bus=%h len=%0d, required 1 b2 8", vld_m, bus_m, len_m);
        end
        n_checks++;
        if (vld_l !== 1'b1 || bus_l !== 8'h4D || len_l !== 4'd8) begin
            n_fail++;
            $display("FAIL basic_lsb vld=%b bus=%h len=%0d, required 1 4d 8", vld_l, bus_l, len_l);
        end
        step();
        n_checks++;
        if (vld_m !== 1'b0 || vld_l !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle vld=%b%b, required 00", vld_m, vld_l);
        end
    endtask

    task automatic test_back_to_back();
        dout_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        n_checks++;
        if (srdy_m !== 1'b0 || vld_m !== 1'b1 || bus_m !== 8'hA5) begin
            n_fail++;
            $display("FAIL bp_full srdy=%b vld=%b bus=%h, required 0 1 a5", srdy_m, vld_m, bus_m);
        end
        repeat (3) step();
        n_checks++;
        if (srdy_l !== 1'b0 || vld_l !== 1'b1 || bus_l !== 8'hA5 || bus_m !== 8'hA5) begin
            n_fail++;
            $display("FAIL bp_hold srdy=%b vld=%b bus=%h/%h, required 0 1 a5/a5", srdy_l, vld_l, bus_m, bus_l);
        end
        dout_ready = 1'b1;
        step();
        n_checks++;
        if (vld_m !== 1'b1 || bus_m !== 8'h3C || srdy_m !== 1'b1 || bus_l !== 8'h3C || srdy_l !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release vld=%b bus=%h/%h srdy=%b%b, required 1 3c/3c 11",
                     vld_m, bus_m, bus_l, srdy_m, srdy_l);
        end
        step();
    endtask

    task automatic test_flush();
        dout_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        flush_only();
        n_checks++;
        if (vld_m !== 1'b1 || bus_m !== 8'h06 || len_m !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_msb vld=%b bus=%h len=%0d, required 1 06 3", vld_m, bus_m, len_m);
        end
        n_checks++;
        if (vld_l !== 1'b1 || bus_l !== 8'h03 || len_l !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_lsb vld=%b bus=%h len=%0d, required 1 03 3", vld_l, bus_l, len_l);
        end
        send_byte(8'h96);
        // Flush together with the completing bit: one normal full word only.
        for (int i = 7; i >= 1; i--) send_bit(i[0], 1'b0);
        send_bit(1'b1, 1'b1);
        // Flush together with the first bit: a one-bit partial word.
        send_bit(1'b1, 1'b1);
        repeat (2) step();
    endtask

    task automatic test_flush_noop();
        dout_ready = 1'b1;
        step();
        flush_only();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (vld_m !== 1'b0 || vld_l !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_noop cyc%0d vld=%b%b, required 00", i, vld_m, vld_l);
            end
            step();
        end
    endtask

    task automatic test_flush_held();
        dout_ready = 1'b0;
        send_byte(8'hC3);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        flush_only();
        n_checks++;
        if (srdy_m !== 1'b0 || srdy_l !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_held_srdy srdy=%b%b, required 00", srdy_m, srdy_l);
        end
        repeat (2) step();
        n_checks++;
        if (srdy_m !== 1'b0 || vld_m !== 1'b1 || bus_m !== 8'hC3) begin
            n_fail++;
            $display("FAIL flush_held_wait srdy=%b vld=%b bus=%h, required 0 1 c3", srdy_m, vld_m, bus_m);
        end
        dout_ready = 1'b1;
        step();
        n_checks++;
        if (vld_m !== 1'b1 || bus_m !== 8'h02 || len_m !== 4'd2 || bus_l !== 8'h01 || len_l !== 4'd2) begin
            n_fail++;
            $display("FAIL flush_held_word vld=%b bus=%h/%h len=%0d/%0d, required 1 02/01 2/2",
                     vld_m, bus_m, bus_l, len_m, len_l);
        end
        n_checks++;
        if (srdy_m !== 1'b1 || srdy_l !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_held_srdy_back srdy=%b%b, required 11", srdy_m, srdy_l);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int p_m, p_l;
        dout_ready = 1'b0;
        send_byte(8'h81);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        #2 reset_ni = 1'b0;
        #1;
        n_checks++;
        if ({vld_m, vld_l, bus_m, bus_l, len_m, len_l} !== '0 || {srdy_m, srdy_l} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_mid vld=%b%b bus=%h/%h len=%0d/%0d srdy=%b%b, required all 0 and srdy 11",
                     vld_m, vld_l, bus_m, bus_l, len_m, len_l, srdy_m, srdy_l);
        end
        q_m.delete();
        q_l.delete();
        model_clear();
        serial_valid = 1'b1;
        serial_data  = 1'b1;
        repeat (2) step();
        serial_valid = 1'b0;
        reset_ni = 1'b1;
        dout_ready = 1'b1;
        step();
        p_m = pops_m;
        p_l = pops_l;
        send_byte(8'hFF);
        repeat (3) step();
        n_checks++;
        if (pops_m - p_m != 1 || pops_l - p_l != 1) begin
            n_fail++;
            $display("FAIL reset_mid_words words=%0d/%0d, required 1/1", pops_m - p_m, pops_l - p_l);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_flush_noop();
        test_flush_held();
        test_reset_mid();
        repeat (5) step();
        n_checks++;
        if (q_m.size() != 0 || q_l.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain pending=%0d/%0d, required 0/0", q_m.size(), q_l.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
